// File: rtl/sync_fifo_pkg.sv
// Shared constants, depth helper and status bundle for the single-clock FIFO.
// The optional first-word fall-through read mode is selected by SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

    localparam int DEF_DATA_SIZE     = 8;
    localparam int DEF_ADDR_SIZE     = 4;
    localparam int DEF_AFULL_THRESH  = 12;
    localparam int DEF_AEMPTY_THRESH = 2;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 w_en,
    input  logic [ADDR_SIZE-1:0] w_addr,
    input  logic [DATA_SIZE-1:0] w_data,
    input  logic [ADDR_SIZE-1:0] r_addr,
    output logic [DATA_SIZE-1:0] r_data
);

    logic [DATA_SIZE-1:0] mem [fifo_depth(ADDR_SIZE)];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is a registered read.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_SIZE     = DEF_DATA_SIZE,
    parameter int ADDR_SIZE     = DEF_ADDR_SIZE,
    parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w_en,
    input  logic [DATA_SIZE-1:0] w_data,
    input  logic                 r_en,
    output logic [DATA_SIZE-1:0] r_data,
    output logic                 r_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr
);

    localparam int                DEPTH       = fifo_depth(ADDR_SIZE);
    localparam logic [ADDR_SIZE:0] DEPTH_CNT  = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AFULL_CNT  = (ADDR_SIZE+1)'(AFULL_THRESH);
    localparam logic [ADDR_SIZE:0] AEMPTY_CNT = (ADDR_SIZE+1)'(AEMPTY_THRESH);

    logic [ADDR_SIZE:0]   w_ptr;
    logic [ADDR_SIZE:0]   r_ptr;
    logic [ADDR_SIZE:0]   count_q;
    logic                 overflow_q;
    logic                 underflow_q;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [DATA_SIZE-1:0] mem_rdata;
    fifo_status_t         status;

    // Handshake: a write is taken when w_en && !full, a read when r_en && !empty,
    // both judged on this cycle's registered count; a refused request is dropped
    // and latched as overflow/underflow instead.
    assign wr_acc = w_en && !status.full;
    assign rd_acc = r_en && !status.empty;

    sync_fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk    (clk),
        .w_en   (wr_acc),
        .w_addr (w_ptr[ADDR_SIZE-1:0]),
        .w_data (w_data),
        .r_addr (r_ptr[ADDR_SIZE-1:0]),
        .r_data (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A fresh error in the same cycle as err_clr must survive the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (w_en && status.full) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
            if (r_en && status.empty) begin
                underflow_q <= 1'b1;
            end else if (err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        status              = '0;
        status.full         = (count_q == DEPTH_CNT);
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= AFULL_CNT);
        status.almost_empty = (count_q <= AEMPTY_CNT);
        status.overflow     = overflow_q;
        status.underflow    = underflow_q;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented straight from storage; r_en pops it.
    assign r_data  = mem_rdata;
    assign r_valid = !status.empty;
`else
    logic [DATA_SIZE-1:0] r_data_q;
    logic                 r_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= rd_acc;
            if (rd_acc) begin
                r_data_q <= mem_rdata;
            end
        end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
`endif

    assign count        = count_q;
    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised successor to the dual-clock FIFO, used where producer and consumer share one clock domain, so no pointer synchronisers are needed.
- Adds a fill-level output and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags with clear.
- Read mode is selectable at compile time: standard registered read or first-word fall-through.
- Sits between same-domain pipeline stages as an elastic buffer.

Parameters:
DATA_SIZE, 8, data word width in bits
ADDR_SIZE, 4, address width; depth DEPTH = 2**ADDR_SIZE
AFULL_THRESH, 12, almost_full asserted when count >= this; legal range 1..DEPTH-1
AEMPTY_THRESH, 2, almost_empty asserted when count <= this; legal range 1..DEPTH-1, must be < AFULL_THRESH

Ports:
clk  input  1  single clock, all logic on the rising edge
rst_n  input  1  asynchronous, active-low reset
w_en  input  1  write request
w_data  input  DATA_SIZE  write data
r_en  input  1  read request
r_data  output  DATA_SIZE  read data
r_valid  output  1  r_data is valid (see modes)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_SIZE+1  current fill level, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
err_clr  input  1  synchronous clear of overflow/underflow

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values:
  - w_ptr, r_ptr and count = 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - r_data=0, r_valid=0, overflow=0, underflow=0.
  - Memory contents are not reset.
- Pointers: ADDR_SIZE+1-bit binary. The low ADDR_SIZE bits address memory; the MSB gives natural wrap-around at DEPTH.
- Write acceptance: wr_acc = w_en && !full, using full from the current cycle's registered state. On wr_acc, mem[w_addr] <= w_data and w_ptr increments.
- Read acceptance: rd_acc = r_en && !empty. On rd_acc, r_ptr increments.
- Count update: count <= count + wr_acc - rd_acc.
  - Simultaneous accepted read and write: count unchanged, both pointers advance.
  - Full with simultaneous w_en and r_en: read accepted, write rejected, overflow set; count becomes DEPTH-1.
  - Empty with simultaneous w_en and r_en: write accepted, read rejected, underflow set; count becomes 1.
- Flag derivation: full, empty, almost_full and almost_empty are derived combinationally from the registered count only. No input-to-output combinational path.
- Error flags:
  - overflow <= 1 on (w_en && full); underflow <= 1 on (r_en && empty).
  - err_clr clears both; a set condition in the same cycle as err_clr wins.
- Write-then-read same address: data written in cycle N is readable from cycle N+1 onward. There is no same-cycle bypass.
- Reset asserted mid-operation: all state returns to reset values immediately, and in-flight data is discarded.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Without the macro (standard mode):
  - r_data is registered and loaded from mem[r_addr] on rd_acc.
  - Read latency is 1 cycle; r_valid pulses high in the cycle after rd_acc.
  - r_data holds its value otherwise.
- With the macro (first-word fall-through):
  - r_data = mem[r_addr] combinationally from the registered pointer.
  - r_valid = !empty.
  - r_en acts as the pop/acknowledge of the presented word, and the next word appears in the following cycle.
  - Flags and count behave identically in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - default constants (DATA_SIZE, ADDR_SIZE, thresholds);
  - a DEPTH calculation function;
  - a typedef for the status bundle {full, empty, almost_full, almost_empty, overflow, underflow}.
- One sub-module, sync_fifo_mem: simple dual-port RAM with synchronous write and asynchronous read, parametrised by DATA_SIZE/ADDR_SIZE.
- Pointer, count and flag logic stays in sync_fifo.

Test Plan:
(Defaults: DEPTH=16, AFULL=12, AEMPTY=2.)
1. Reset then idle -> empty=1, almost_empty=1, count=0, full=0, r_valid=0, all flags 0.
2. Write 0x00..0x0F on consecutive cycles -> count reaches 16, full=1 after the 16th write. almost_full rises when count=12. almost_empty falls when count=3.
3. Write 0xAA while full -> count stays 16, overflow=1, memory unchanged; err_clr pulse -> overflow=0.
4. Read 16 words -> data 0x00..0x0F in order (standard mode: each word 1 cycle after r_en; FWFT: head word visible before r_en). Ends with empty=1. An extra r_en sets underflow=1.
5. Simultaneous w_en/r_en streaming for 40 cycles at count=5 -> count holds at 5, pointers wrap past 16, data order preserved.
6. Assert rst_n=0 mid-stream at count=9 -> count=0, empty=1, r_valid=0 asynchronously. A subsequent write of 0x5A reads back as 0x5A.
